// File: rtl/rv32i_pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage rv32i pipeline: load-use bubbles, redirect and
// trap flush sequencing, data-memory wait holds, and a saturating stall-cycle counter.
module rv32i_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [4:0]           i_dec_rs1_addr,
    input  logic [4:0]           i_dec_rs2_addr,
    input  logic [4:0]           i_ex_rd_addr,
    input  logic                 i_ex_load,
    input  logic                 i_ex_valid,
    input  logic                 i_branch_taken,
    input  logic                 i_trap,
    input  logic                 i_mem_busy,
    input  logic                 i_cnt_clr,
    output logic                 o_stall_if,
    output logic                 o_stall_id,
    output logic                 o_stall_ex,
    output logic                 o_bubble_ex,
    output logic                 o_flush_if,
    output logic                 o_flush_id,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_stall_cnt
);

    localparam int MAX_CYCLES = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        RUN,
        LD_STALL,
        FLUSH,
        MEM_WAIT,
        TRAP
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          next_cnt;
    logic [CNT_WIDTH-1:0]   stall_cnt;

    logic load_use;
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic bubble_ex;
    logic flush_if;
    logic flush_id;

    assign load_use = i_ex_valid & i_ex_load & (i_ex_rd_addr != 5'd0) &
                      ((i_ex_rd_addr == i_dec_rs1_addr) | (i_ex_rd_addr == i_dec_rs2_addr));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // The cycle that accepts a trap or redirect is itself the first flush cycle,
    // so the counter is loaded with the number of flush cycles still owed.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;

        case (state)
            RUN, LD_STALL: begin
                if (i_trap) begin
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    next_cnt   = DRAIN_LOAD;
                    next_state = (DRAIN_CYCLES > 1) ? TRAP : RUN;
                end else if (i_branch_taken) begin
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    next_cnt   = FLUSH_LOAD;
                    next_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (i_mem_busy) begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    next_state = MEM_WAIT;
                end else if (load_use && (state == RUN)) begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    bubble_ex  = 1'b1;
                    next_state = LD_STALL;
                end else begin
                    next_state = RUN;
                end
            end

            FLUSH: begin
                flush_if = 1'b1;
                flush_id = 1'b1;
                if (i_trap) begin
                    next_cnt   = DRAIN_LOAD;
                    next_state = (DRAIN_CYCLES > 1) ? TRAP : RUN;
                end else begin
                    stall_ex = i_mem_busy;
                    next_cnt = cnt - CW'(1);
                    if (next_cnt == '0) begin
                        next_state = RUN;
                    end
                end
            end

            // A redirect cannot arrive here: the branch sits frozen in EX.
            MEM_WAIT: begin
                if (i_trap) begin
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    next_cnt   = DRAIN_LOAD;
                    next_state = (DRAIN_CYCLES > 1) ? TRAP : RUN;
                end else if (i_mem_busy) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else begin
                    next_state = RUN;
                end
            end

            TRAP: begin
                flush_if = 1'b1;
                flush_id = 1'b1;
                next_cnt = cnt - CW'(1);
                if (next_cnt == '0) begin
                    next_state = RUN;
                end
            end

            default: begin
                next_state = RUN;
                next_cnt   = '0;
            end
        endcase
    end

    assign o_stall_if  = ~i_rst & stall_if;
    assign o_stall_id  = ~i_rst & stall_id;
    assign o_stall_ex  = ~i_rst & stall_ex;
    assign o_bubble_ex = ~i_rst & bubble_ex;
    assign o_flush_if  = ~i_rst & flush_if;
    assign o_flush_id  = ~i_rst & flush_id;
    assign o_busy      = ~i_rst & (state != RUN);

    // A clear in a stalled cycle still counts that cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (i_cnt_clr) begin
            stall_cnt <= CNT_WIDTH'(o_stall_id);
        end else if (o_stall_id && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_stall_cnt = stall_cnt;

endmodule
